// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select, A over B on a tie
// unless DMEM_ARB_ROUND_ROBIN_EN, which favours the port that did not win last
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic  a_req,
    input  logic  b_req,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  port_t last,
`endif
    output port_t win
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_comb win = (a_req && b_req) ? (last == PORT_A ? PORT_B : PORT_A) : (a_req ? PORT_A : PORT_B);
`else
    always_comb win = a_req ? PORT_A : PORT_B;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a registered-read data memory between CPU (A) and DMA (B) requesters
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie break instead of fixed A priority
module dmem_arbiter #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_arb_pkg::*;
    state_t state;
    port_t win, sel;
    logic lwe, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    port_t last;
    dmem_arb_pick u_pick (.a_req(a_req), .b_req(b_req), .last(last), .win(win));
`else
    dmem_arb_pick u_pick (.a_req(a_req), .b_req(b_req), .win(win));
`endif
    always_comb begin
        we    = win == PORT_A ? a_we : b_we;
        addr  = win == PORT_A ? a_addr : b_addr;
        wdata = win == PORT_A ? a_wdata : b_wdata;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel       <= PORT_A;
            lwe       <= 1'b0;
            a_gnt     <= 1'b0;
            a_done    <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= '0;
            b_gnt     <= 1'b0;
            b_done    <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last      <= PORT_B;
`endif
        end else begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_err  <= 1'b0;
            b_err  <= 1'b0;
            case (state)
                IDLE: if (a_req || b_req) begin
                    sel   <= win;
                    lwe   <= we;
                    a_gnt <= win == PORT_A;
                    b_gnt <= win == PORT_B;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    last  <= win;
`endif
                    // misaligned words never reach the memory
                    if (|(addr[1:0] & WORD_ALIGN_MASK)) state <= RESP;
                    else begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_read  <= !we;
                        mem_write <= we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    a_done <= sel == PORT_A;
                    b_done <= sel == PORT_B;
                    if (sel == PORT_A && !lwe) a_rdata <= mem_rdata;
                    if (sel == PORT_B && !lwe) b_rdata <= mem_rdata;
                    state  <= IDLE;
                end
                default: begin
                    a_done <= sel == PORT_A;
                    b_done <= sel == PORT_B;
                    a_err  <= sel == PORT_A;
                    b_err  <= sel == PORT_B;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench with a big-endian byte memory and a word-level reference model
module tb_dmem_arbiter;
    logic clock = 1'b0, reset_n = 1'b0;
    logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_read, mem_write;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [7:0] mem [0:255];
    logic [31:0] model [0:63];
    logic last_b = 1'b1;
    int total = 0, bad = 0, strobes = 0;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // registered-read big-endian memory, 256 bytes
    always @(posedge clock) begin
        if (mem_write) begin
            mem[{mem_addr[7:2], 2'd0}] <= mem_wdata[31:24];
            mem[{mem_addr[7:2], 2'd1}] <= mem_wdata[23:16];
            mem[{mem_addr[7:2], 2'd2}] <= mem_wdata[15:8];
            mem[{mem_addr[7:2], 2'd3}] <= mem_wdata[7:0];
        end
        if (mem_read)
            mem_rdata <= {mem[{mem_addr[7:2], 2'd0}], mem[{mem_addr[7:2], 2'd1}],
                          mem[{mem_addr[7:2], 2'd2}], mem[{mem_addr[7:2], 2'd3}]};
    end

    always @(negedge clock) if (mem_read || mem_write) begin
        strobes++;
        check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
        check("strobe_align", 32'(mem_addr[1:0]), 32'd0);
    end

    function automatic logic pick_b(input logic a, input logic b);
        if (!a) return 1'b1;
        if (!b) return 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return !last_b;
`else
        return 1'b0;
`endif
    endfunction

    // one access by whichever port is expected to win; request(s) already driven
    task automatic txn(input logic exp_b);
        logic we, err, dn;
        logic [31:0] ad, wd, ra, rb, rd;
        int n, s0;
        we  = exp_b ? b_we : a_we;
        ad  = exp_b ? b_addr : a_addr;
        wd  = exp_b ? b_wdata : a_wdata;
        err = ad[1:0] != 2'd0;
        @(posedge clock); #1;
        check("gnt", {30'd0, a_gnt, b_gnt}, exp_b ? 32'd1 : 32'd2);
        last_b = exp_b;
        ra = a_rdata;
        rb = b_rdata;
        s0 = strobes;
        if (!err) begin
            check("mem_addr", mem_addr, ad);
            check("mem_rw", {30'd0, mem_read, mem_write}, we ? 32'd1 : 32'd2);
        end
        if (exp_b) begin b_addr = $urandom & 32'hFC; b_wdata = $urandom; end
        else begin a_addr = $urandom & 32'hFC; a_wdata = $urandom; end
        n = 0;
        dn = 1'b0;
        while (!dn && n < 6) begin
            @(posedge clock); #1;
            n++;
            dn = exp_b ? b_done : a_done;
        end
        check("done_lat", n, err ? 32'd1 : 32'd2);
        check("err", 32'(exp_b ? b_err : a_err), 32'(err));
        check("strobe_cnt", strobes - s0, err ? 32'd0 : 32'd1);
        check("other_rdata", exp_b ? a_rdata : b_rdata, exp_b ? ra : rb);
        rd = exp_b ? b_rdata : a_rdata;
        if (err) check("rdata_hold", rd, exp_b ? rb : ra);
        else if (!we) check("rdata", rd, model[ad[7:2]]);
        if (!err && we) model[ad[7:2]] = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
        for (int i = 0; i < 64; i++) model[i] = {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]};
        repeat (3) @(posedge clock);
        #1;
        check("rst_ctrl", {22'd0, a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_read, mem_write, 2'd0}, 32'd0);
        check("rst_rdata", a_rdata | b_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset_n = 1'b1;
        last_b = 1'b1;
        @(posedge clock); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        txn(1'b0);
        check("deadbeef", a_rdata, 32'hDEADBEEF);
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h12345678;
        txn(1'b1);
        b_we = 1'b0; b_addr = 32'h20;
        txn(1'b1);
        check("b_readback", b_rdata, 32'h12345678);
        b_req = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 32'h40; b_addr = 32'h80;
        for (int i = 0; i < 4; i++) txn(pick_b(1'b1, 1'b1));
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clock); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h22;
        txn(1'b0);
        a_req = 1'b0;
        @(posedge clock); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        @(posedge clock); #1;
        check("rst_gnt", 32'(a_gnt), 32'd1);
        check("rst_pre_read", 32'(mem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_read_drop", 32'(mem_read), 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
            check("rst_no_done", 32'(a_done | b_done), 32'd0);
        end
        reset_n = 1'b1;
        last_b = 1'b1;
        txn(1'b0);
        a_req = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 40; i++) begin
            a_req = 1'($urandom_range(0, 1));
            b_req = a_req ? 1'($urandom_range(0, 1)) : 1'b1;
            a_we = 1'($urandom_range(0, 1));
            b_we = 1'($urandom_range(0, 1));
            a_addr = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFF : 32'hFC);
            b_addr = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFF : 32'hFC);
            a_wdata = $urandom;
            b_wdata = $urandom;
            txn(pick_b(a_req, b_req));
            a_req = 1'b0; b_req = 1'b0;
            @(posedge clock); #1;
            check("dropped_no_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed, big-endian data memory between two requesters.
- Port A is the CPU load/store stage. Port B is the DMA/debug loader.
- Sequences each access through the memory's registered one-cycle read.
- Returns read data and a completion pulse to the winning requester. Rejects misaligned word accesses.

Parameters:
- ADDR_W, 32, byte-address width for requester and memory addresses.
- DATA_W, 32, word width; fixed at 4 bytes.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held until a_done.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  one-cycle pulse when port A's request is accepted.
- a_done  out  1  one-cycle pulse when port A's access completes.
- a_err  out  1  valid with a_done; 1 = misaligned address, no memory access made.
- a_rdata  out  DATA_W  read data, valid with a_done when a_we=0 and a_err=0.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_err, b_rdata: same as port A, for port B.
- mem_read  out  1  to memory MemoryRead.
- mem_write  out  1  to memory MemoryWrite.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory InputData.
- mem_rdata  in  DATA_W  from memory OutputData.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, last-winner register = B, so A wins the first tie.
- All outputs are registered.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise pick a winner: fixed priority A over B. See Optional Feature for round-robin.
  - Latch the winner's we/addr/wdata and pulse its gnt.
  - addr[1:0] != 0: go to RESP with err=1, no memory strobe.
  - Otherwise drive mem_addr/mem_wdata and mem_read=~we or mem_write=we; go to ACCESS.
- ACCESS, one cycle:
  - Strobes are held; the memory samples them at the closing edge.
  - Deassert strobes; go to WAIT.
- WAIT, one cycle:
  - mem_rdata is now valid; capture it into the winner's rdata.
  - Pulse the winner's done; go to IDLE.
- RESP, error path:
  - Pulse the winner's done with err=1; rdata is unchanged; go to IDLE.
- Latency:
  - Request sampled at edge k: gnt high after edge k, done high after edge k+2.
  - Error path: done high after edge k+1.
- Throughput: at most one access per 3 cycles.
- Simultaneous a_req and b_req: exactly one gnt; the loser stays pending and is served next IDLE.
- A request deasserted before its gnt is dropped silently.
- A request changed after gnt has no effect; the latched values are used.
- Only the winner's done, err and rdata are updated. The other port's rdata holds its last value.
- mem_read and mem_write are never high together.
- mem_addr is always word-aligned, so byte address+3 never crosses a word.
- reset_n low mid-access: FSM goes to IDLE and strobes drop immediately. No done is issued; the requester retries.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the port that did not win last is granted. The last-winner register updates on every gnt.
- Undefined: fixed priority, A always wins ties. The last-winner register is absent.

Decomposition:
- Package dmem_arb_pkg:
  - FSM state enum: IDLE, ACCESS, WAIT, RESP.
  - Requester-id type: PORT_A, PORT_B.
  - Constants: ADDR_W, DATA_W, WORD_ALIGN_MASK = 2'b11.
- Sub-module dmem_arb_pick: combinational winner select from a_req, b_req and the last-winner input, including the round-robin logic. The top level contains the FSM and the datapath registers.

Test Plan:
- Port A reads 0x00000010 with memory bytes 10..13 = DE AD BE EF -> a_gnt after edge k, a_done after edge k+2, a_rdata=0xDEADBEEF, a_err=0.
- Port B writes 0x12345678 to 0x20, then reads 0x20 -> mem_write one cycle with mem_addr=0x20; the read returns 0x12345678.
- a_req and b_req both asserted and held for 4 accesses:
  - Without the macro: grant order A,A,A,A, and B waits.
  - With DMEM_ARB_ROUND_ROBIN_EN: grant order A,B,A,B.
- a_req read at 0x00000022 -> a_err=1 with a_done after edge k+1; mem_read and mem_write stay 0.
- reset_n pulled low during ACCESS -> mem_read drops without waiting for an edge. No done is issued, and a re-request after release completes normally.
